// File: rtl/parity_arbiter.sv
// rtl/parity_arbiter.sv - round-robin arbiter sharing one parity unit, registered result with valid/ack
module parity_arbiter #(
    parameter int  NREQ  = 4,
    parameter int  WIDTH = 5,
    localparam int ID_W  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] sw_bus,
    output logic [NREQ-1:0]       gnt,
    output logic                  led,
    output logic                  led_valid,
    output logic [ID_W-1:0]       led_id,
    input  logic                  ack,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EVAL   = 2'd1,
        RESULT = 2'd2
    } state_t;

    state_t             state_q, state_d;

    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic [WIDTH-1:0]   word_q, word_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [ID_W-1:0]    rr_q, rr_d;
    logic               led_q, led_d;
    logic               led_valid_q, led_valid_d;
    logic [ID_W-1:0]    led_id_q, led_id_d;
    logic               busy_q, busy_d;

    // Arbitration results, valid only while the FSM is in IDLE
    logic               pick_found;
    logic [ID_W-1:0]    pick_idx;
    logic [WIDTH-1:0]   pick_word;
    logic [ID_W-1:0]    pick_next_rr;

    // Round-robin search: first asserted request starting at rr, wrapping modulo NREQ
    always_comb begin
        logic [ID_W:0] cand;
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_q} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NREQ)) begin
                cand = cand - (ID_W+1)'(NREQ);
            end
            if (!pick_found && req[cand[ID_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[ID_W-1:0];
            end
        end
    end

    // Select the winner's switch word and the pointer value just past it
    always_comb begin
        pick_word = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == ID_W'(i)) begin
                pick_word = sw_bus[i*WIDTH +: WIDTH];
            end
        end
        if (pick_idx == ID_W'(NREQ-1)) begin
            pick_next_rr = '0;
        end else begin
            pick_next_rr = pick_idx + ID_W'(1);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> EVAL on a grant, EVAL -> RESULT always, RESULT -> IDLE on ack
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = EVAL;
                end
            end
            EVAL: begin
                state_d = RESULT;
            end
            RESULT: begin
                if (ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output/datapath next values; everything visible outside is registered
    always_comb begin
        gnt_d       = '0;
        word_d      = word_q;
        id_d        = id_q;
        rr_d        = rr_q;
        led_d       = led_q;
        led_valid_d = led_valid_q;
        led_id_d    = led_id_q;
        case (state_q)
            IDLE: begin
                led_valid_d = 1'b0;
                if (pick_found) begin
                    gnt_d  = NREQ'(1) << pick_idx;
                    word_d = pick_word;
                    id_d   = pick_idx;
                    rr_d   = pick_next_rr;
                end
            end
            EVAL: begin
                led_d       = ^word_q;
                led_id_d    = id_q;
                led_valid_d = 1'b1;
            end
            RESULT: begin
                // led and led_id stay put after ack; only the valid flag drops
                if (ack) begin
                    led_valid_d = 1'b0;
                end
            end
            default: begin
                led_valid_d = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // Datapath and output registers; reset discards any pending result
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q       <= '0;
            word_q      <= '0;
            id_q        <= '0;
            rr_q        <= '0;
            led_q       <= 1'b0;
            led_valid_q <= 1'b0;
            led_id_q    <= '0;
            busy_q      <= 1'b0;
        end else begin
            gnt_q       <= gnt_d;
            word_q      <= word_d;
            id_q        <= id_d;
            rr_q        <= rr_d;
            led_q       <= led_d;
            led_valid_q <= led_valid_d;
            led_id_q    <= led_id_d;
            busy_q      <= busy_d;
        end
    end

    assign gnt       = gnt_q;
    assign led       = led_q;
    assign led_valid = led_valid_q;
    assign led_id    = led_id_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_parity_arbiter.sv
// tb/tb_parity_arbiter.sv - self-checking bench for parity_arbiter
module tb_parity_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 5;
    localparam int ID_W  = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] sw_bus;
    logic [NREQ-1:0]       gnt;
    logic                  led;
    logic                  led_valid;
    logic [ID_W-1:0]       led_id;
    logic                  ack;
    logic                  busy;

    parity_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .sw_bus    (sw_bus),
        .gnt       (gnt),
        .led       (led),
        .led_valid (led_valid),
        .led_id    (led_id),
        .ack       (ack),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NREQ-1:0]       req;
        logic [NREQ*WIDTH-1:0] bus;
        int                    exp_id;
        logic                  exp_led;
    } vec_t;

    typedef struct {
        int   id;
        logic led;
    } exp_t;

    vec_t tbl[8];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic logic [19:0] mk(input logic [4:0] w3, input logic [4:0] w2,
                                       input logic [4:0] w1, input logic [4:0] w0);
        return {w3, w2, w1, w0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_gnt(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (gnt != '0) begin
                ok = 1'b1;
                break;
            end
        end
        check("gnt_timeout", 32'(ok), 32'd1);
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (led_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("valid_timeout", 32'(ok), 32'd1);
    endtask

    task automatic pop_compare();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("led", 32'(led), 32'(e.led));
            check("led_id", 32'(led_id), 32'(e.id));
        end
    endtask

    // One complete transaction with ack held high; requester drops after its grant
    task automatic run_txn(input vec_t v);
        bit ok;
        req    = v.req;
        sw_bus = v.bus;
        ack    = 1'b1;
        wait_gnt(ok);
        if (ok) begin
            check("gnt", 32'(gnt), 32'(1) << v.exp_id);
            sb.push_back('{id: v.exp_id, led: v.exp_led});
            req    = '0;
            sw_bus = ~v.bus;
            @(negedge clk);
            check("gnt_pulse", 32'(gnt), 32'd0);
            check("valid_latency", 32'(led_valid), 32'd1);
            wait_valid(ok);
            if (ok) pop_compare();
            @(negedge clk);
            check("valid_clear", 32'(led_valid), 32'd0);
            check("busy_clear", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        tbl[0] = '{4'b0100, mk(5'h0B, 5'b10110, 5'h07, 5'h01), 2, 1'b1};
        tbl[1] = '{4'b0011, mk(5'h1F, 5'h00, 5'h15, 5'b00111), 0, 1'b1};
        tbl[2] = '{4'b0011, mk(5'h00, 5'h1F, 5'b11000, 5'h01), 1, 1'b0};
        tbl[3] = '{4'b1001, mk(5'b11111, 5'h03, 5'h01, 5'h00), 3, 1'b1};
        tbl[4] = '{4'b1000, mk(5'b00000, 5'h01, 5'h01, 5'h01), 3, 1'b0};
        tbl[5] = '{4'b0110, mk(5'h01, 5'h07, 5'b10101, 5'h01), 1, 1'b1};
        tbl[6] = '{4'b0110, mk(5'h01, 5'b01111, 5'h01, 5'h01), 2, 1'b0};
        tbl[7] = '{4'b0001, mk(5'h1E, 5'h1E, 5'h1E, 5'b00001), 0, 1'b1};

        // Reset with every requester active
        rst    = 1'b1;
        req    = 4'hF;
        sw_bus = mk(5'h1F, 5'h1F, 5'h1F, 5'h1F);
        ack    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_led", 32'(led), 32'd0);
        check("rst_valid", 32'(led_valid), 32'd0);
        check("rst_led_id", 32'(led_id), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        req = '0;

        // Table: single transactions walking the round-robin pointer
        for (int i = 0; i < 8; i++) begin
            run_txn(tbl[i]);
        end

        // All requesters held high after a fresh reset: grants 0,1,2,3,0
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        rst    = 1'b0;
        req    = 4'hF;
        ack    = 1'b1;
        sw_bus = mk(5'h1F, 5'h03, 5'h01, 5'h00);
        for (int k = 0; k < 5; k++) begin
            wait_gnt(ok);
            if (!ok) break;
            check("rr_gnt", 32'(gnt), 32'(1) << (k % 4));
            sb.push_back('{id: k % 4, led: (k % 2 == 1)});
            @(negedge clk);
            wait_valid(ok);
            if (ok) pop_compare();
        end
        req = '0;
        @(negedge clk);
        @(negedge clk);
        check("rr_idle", 32'(busy), 32'd0);

        // Backpressure: result held while ack stays low (rr is now 1)
        ack    = 1'b0;
        req    = 4'b0010;
        sw_bus = mk(5'h00, 5'h00, 5'b00111, 5'h00);
        wait_gnt(ok);
        if (ok) begin
            check("bp_gnt", 32'(gnt), 32'b0010);
            sb.push_back('{id: 1, led: 1'b1});
            req = '0;
            @(negedge clk);
            wait_valid(ok);
            if (ok) pop_compare();
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                check("bp_valid", 32'(led_valid), 32'd1);
                check("bp_led", 32'(led), 32'd1);
                check("bp_led_id", 32'(led_id), 32'd1);
                check("bp_gnt_quiet", 32'(gnt), 32'd0);
                check("bp_busy", 32'(busy), 32'd1);
            end
            ack = 1'b1;
            @(negedge clk);
            check("bp_ack_clear", 32'(led_valid), 32'd0);
            check("bp_led_kept", 32'(led), 32'd1);
        end

        // Reset while in EVAL (rr is 2, so requester 2 wins first)
        req    = 4'b0100;
        sw_bus = mk(5'h00, 5'h01, 5'h00, 5'h00);
        wait_gnt(ok);
        if (ok) begin
            check("mid_gnt", 32'(gnt), 32'b0100);
            rst = 1'b1;
            req = '0;
            @(negedge clk);
            check("mid_valid", 32'(led_valid), 32'd0);
            check("mid_led", 32'(led), 32'd0);
            check("mid_busy", 32'(busy), 32'd0);
            check("mid_gnt_clr", 32'(gnt), 32'd0);
        end
        rst    = 1'b0;
        req    = 4'b1001;
        sw_bus = mk(5'h03, 5'h00, 5'h00, 5'h01);
        ack    = 1'b1;
        wait_gnt(ok);
        if (ok) begin
            check("post_rst_gnt", 32'(gnt), 32'b0001);
            sb.push_back('{id: 0, led: 1'b1});
            req = '0;
            @(negedge clk);
            wait_valid(ok);
            if (ok) pop_compare();
            @(negedge clk);
        end

        // Spurious ack in IDLE with no requests
        req = '0;
        ack = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("sp_valid", 32'(led_valid), 32'd0);
            check("sp_busy", 32'(busy), 32'd0);
            check("sp_gnt", 32'(gnt), 32'd0);
        end

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
